// File: rtl/stock_feed_pkg.sv
// Shared types for the stock feed sequencer: FSM states, buffer depth and entry layout.
// Combinational only; no backpressure of its own.
package stock_feed_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } feed_state_e;

  localparam int FEED_BUF_DEPTH  = 2;
  localparam int FEED_CNT_W      = 2;
  localparam int FEED_DATA_WIDTH = 8;

  typedef struct packed {
    logic [FEED_DATA_WIDTH-1:0] data;
    logic                       last;
  } feed_entry_t;

endpackage

// File: rtl/feed_skid_fifo.sv
// Two-entry FIFO that absorbs the ROM read latency; head is visible the cycle after push.
// Never refuses a push: the parent's issue rule keeps buffered + in-flight reads within depth.
module feed_skid_fifo
  import stock_feed_pkg::*;
#(
  parameter type entry_t = feed_entry_t
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  entry_t                push_dat,
  input  logic                  pop,
  output entry_t                head,
  output logic [FEED_CNT_W-1:0] count
);

  entry_t                mem_q [FEED_BUF_DEPTH];
  entry_t                mem_d [FEED_BUF_DEPTH];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [FEED_CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/stock_feed_sequencer.sv
// Replays a ROM address window as a valid/ready tick stream, once or looping; first tick 2 cycles after start.
// Reads issue only while buffered + pending - pop < 2, so stalls never drop or repeat a tick.
module stock_feed_sequencer
  import stock_feed_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_dout,
  output logic [DATA_WIDTH-1:0]    tick_data,
  output logic                     tick_valid,
  input  logic                     tick_ready,
  output logic                     tick_last,
  output logic                     busy,
  output logic                     done
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } tick_entry_t;

  feed_state_e              state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [ADDRESS_WIDTH:0]   len_q, len_d;
  logic [ADDRESS_WIDTH:0]   idx_q, idx_d;
  logic                     loop_q, loop_d;
  logic                     rd_pending_q, rd_pending_d;
  logic                     rd_last_q, rd_last_d;
  logic                     done_q, done_d;

  tick_entry_t           push_dat, head;
  logic [FEED_CNT_W-1:0] fifo_count;
  logic                  pop, flush, issue, last_idx;

  assign tick_valid = (fifo_count != '0);
  assign pop        = tick_valid & tick_ready;
  assign push_dat   = '{data: rom_dout, last: rd_last_q};
  assign last_idx   = (idx_q == len_q - (ADDRESS_WIDTH+1)'(1));
  // A slot freed by this cycle's pop can be refilled by a read issued in the same cycle.
  assign issue      = (state_q == RUN) &&
                      (({1'b0, fifo_count} + {2'b0, rd_pending_q}) <
                       (3'(FEED_BUF_DEPTH) + {2'b0, pop}));

  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    base_d       = base_q;
    len_d        = len_q;
    idx_d        = idx_q;
    loop_d       = loop_q;
    rd_pending_d = 1'b0;
    rd_last_d    = rd_last_q;
    done_d       = 1'b0;
    flush        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            base_d     = base_addr;
            len_d      = length;
            loop_d     = loop_en;
            rom_addr_d = base_addr;
            idx_d      = '0;
            state_d    = RUN;
          end
        end
      end
      RUN, DRAIN: begin
        if (stop) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (state_q == RUN) begin
          if (issue) begin
            rd_pending_d = 1'b1;
            rd_last_d    = last_idx;
            rom_addr_d   = rom_addr_q + ADDRESS_WIDTH'(1);
            idx_d        = idx_q + (ADDRESS_WIDTH+1)'(1);
            if (last_idx) begin
              if (loop_q) begin
                rom_addr_d = base_q;
                idx_d      = '0;
              end else begin
                state_d = DRAIN;
              end
            end
          end
        end else if (fifo_count == '0 && !rd_pending_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rom_addr_q   <= '0;
      base_q       <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      loop_q       <= 1'b0;
      rd_pending_q <= 1'b0;
      rd_last_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      base_q       <= base_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      loop_q       <= loop_d;
      rd_pending_q <= rd_pending_d;
      rd_last_q    <= rd_last_d;
      done_q       <= done_d;
    end
  end

  feed_skid_fifo #(.entry_t(tick_entry_t)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (rd_pending_q),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count)
  );

  assign rom_addr  = rom_addr_q;
  assign tick_data = tick_valid ? head.data : '0;
  assign tick_last = tick_valid & head.last;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_stock_feed_sequencer.sv
// Scoreboard bench: the driver queues expected ticks from window rules, a negedge monitor pops and compares.
module tb_stock_feed_sequencer;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic          tick_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;
  logic [DW-1:0] tick_data;
  logic          tick_valid, tick_last, busy, done;

  logic [7:0] rom_mem [0:65535];

  stock_feed_sequencer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .base_addr  (base_addr),
    .length     (length),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .tick_data  (tick_data),
    .tick_valid (tick_valid),
    .tick_ready (tick_ready),
    .tick_last  (tick_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 65536; i++) rom_mem[i] = i[7:0];

  always @(posedge clk) rom_dout <= rom_mem[rom_addr];

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         acc_cnt = 0;
  int         done_cnt = 0;
  logic       rdy_rand = 1'b0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares every accepted tick with the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (prev_hold) begin
        check("stall_valid_held", tick_valid, 1);
        check("stall_data_stable", tick_data, prev_data);
      end
      check("inflight_le_2", int'(dut.u_fifo.count_q) + int'(dut.rd_pending_q) <= 2, 1);
      if (tick_valid && tick_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick: got 0x%0h, no tick expected at %0t", tick_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("tick_data", tick_data, e.d);
          check("tick_last", tick_last, e.l);
        end
      end
      if (done) begin
        done_cnt++;
        check("busy_low_with_done", busy, 0);
      end
    end
    prev_hold = tick_valid && !tick_ready && !stop && !rst;
    prev_data = tick_data;
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rdy_rand) tick_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_window(input int b, input int n, input int reps);
    exp_t e;
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < n; i++) begin
        e.d = 8'((b + i) & 255);
        e.l = (i == n - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_start(input int b, input int n, input logic lp);
    base_addr = AW'(b);
    length    = (AW+1)'(n);
    loop_en   = lp;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    check(name, exp_q.size(), 0);
    check({name, "_idle"}, busy, 0);
    tick();
  endtask

  initial begin
    int d0, a0, k;
    logic pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_rom_addr", rom_addr, 0);
    check("rst_tick_valid", tick_valid, 0);
    check("rst_tick_last", tick_last, 0);
    check("rst_tick_data", tick_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // Basic window with latency and back-to-back ticks.
    tick_ready = 1'b1;
    d0 = done_cnt;
    push_window(16'h0010, 4, 1);
    do_start(16'h0010, 4, 1'b0);
    check("lat_cycle1_valid", tick_valid, 0);
    tick();
    check("lat_cycle2_valid", tick_valid, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("stream_valid", tick_valid, 1);
      check("stream_data", tick_data, 16 + i);
      check("stream_last", tick_last, (i == 3) ? 1 : 0);
      tick();
    end
    wait_drain("basic_drain", 50);
    check("basic_done_once", done_cnt - d0, 1);

    // Same window under a fixed ready pattern, starting from a full buffer.
    tick_ready = 1'b0;
    d0 = done_cnt;
    push_window(16'h0010, 4, 1);
    do_start(16'h0010, 4, 1'b0);
    k = 0;
    while (!tick_valid && k < 20) begin
      tick();
      k++;
    end
    check("pattern_first_valid", tick_valid, 1);
    tick();
    for (int i = 0; i < 7; i++) begin
      tick_ready = pat[i];
      tick();
    end
    tick_ready = 1'b1;
    wait_drain("pattern_drain", 50);
    check("pattern_done_once", done_cnt - d0, 1);

    // Address wrap.
    d0 = done_cnt;
    push_window(16'hFFFE, 4, 1);
    do_start(16'hFFFE, 4, 1'b0);
    check("wrap_addr0", rom_addr, 16'hFFFE);
    tick();
    check("wrap_addr1", rom_addr, 16'hFFFF);
    tick();
    check("wrap_addr2", rom_addr, 16'h0000);
    tick();
    check("wrap_addr3", rom_addr, 16'h0001);
    wait_drain("wrap_drain", 50);
    check("wrap_done_once", done_cnt - d0, 1);

    // Looping replay aborted after seven accepted ticks.
    d0 = done_cnt;
    a0 = acc_cnt;
    push_window(5, 3, 3);
    do_start(5, 3, 1'b1);
    k = 0;
    while (acc_cnt < a0 + 7 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    stop = 1'b1;
    tick_ready = 1'b0;
    check("loop_reached_7", acc_cnt - a0, 7);
    tick();
    stop = 1'b0;
    check("stop_tick_valid", tick_valid, 0);
    check("stop_busy", busy, 0);
    check("stop_done", done, 0);
    exp_q.delete();
    repeat (3) tick();
    check("stop_no_done", done_cnt - d0, 0);

    // Zero-length start.
    tick_ready = 1'b1;
    d0 = done_cnt;
    do_start(16'h0040, 0, 1'b0);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    tick();
    check("len0_done_pulse", done, 0);
    repeat (3) begin
      check("len0_no_valid", tick_valid, 0);
      tick();
    end
    check("len0_done_once", done_cnt - d0, 1);

    // Start pulsed while busy is ignored.
    rdy_rand = 1'b1;
    d0 = done_cnt;
    push_window(16'h0020, 6, 1);
    do_start(16'h0020, 6, 1'b0);
    repeat (3) tick();
    base_addr = 16'h0099;
    length    = 2;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    wait_drain("midstart_drain", 100);
    check("midstart_done_once", done_cnt - d0, 1);

    // Reset with the buffer full, then replay.
    rdy_rand = 1'b0;
    tick();
    tick_ready = 1'b0;
    push_window(16'h0030, 8, 1);
    do_start(16'h0030, 8, 1'b0);
    repeat (4) tick();
    check("prereset_full", dut.u_fifo.count_q, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("mrst_rom_addr", rom_addr, 0);
    check("mrst_tick_valid", tick_valid, 0);
    check("mrst_tick_last", tick_last, 0);
    check("mrst_tick_data", tick_data, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    rdy_rand = 1'b1;
    d0 = done_cnt;
    push_window(16'h0030, 8, 1);
    do_start(16'h0030, 8, 1'b0);
    wait_drain("replay_drain", 200);
    check("replay_done_once", done_cnt - d0, 1);

    // Random windows under random backpressure.
    for (int t = 0; t < 6; t++) begin
      int b, n;
      b  = int'($urandom_range(0, 65535));
      n  = int'($urandom_range(1, 12));
      d0 = done_cnt;
      push_window(b, n, 1);
      do_start(b, n, 1'b0);
      wait_drain("rand_drain", 300);
      check("rand_done_once", done_cnt - d0, 1);
    end
    rdy_rand = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
